ins_prefetch: RTL and testbench

INS_PREFETCH -- requirements
Module: ins_prefetch

---
 rtl/ins_prefetch_pkg.sv | 19 +
 rtl/prefetch_fifo.sv | 70 +++++++
 rtl/ins_prefetch.sv | 141 ++++++++++++++
 tb/tb_ins_prefetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ins_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ins_prefetch_pkg
// Description : Shared defaults for the instruction prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package ins_prefetch_pkg;

  // Default program address width (64 KiB program space)
  localparam int DEF_ADDR_W = 16;
  // Default instruction byte width
  localparam int DEF_DATA_W = 8;
  // Default queue depth; must be a power of two and at least 2
  localparam int DEF_DEPTH  = 4;
  // 8051 reset vector
  localparam int RESET_PC   = 0;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Synchronous DEPTH x DATA_W FIFO with flush. Head data reads
//               as zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign w_push   = push & ~full;
  assign w_pop    = pop & ~empty;
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ins_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ins_prefetch
// Description : Instruction byte prefetch queue for an 8051-style core.
//               Issues sequential program-memory reads, buffers bytes in a
//               small FIFO and hands them to the CPU with their address.
//               Optional macro PREFETCH_WAIT_EN adds a mem_ready handshake
//               (request held until ready, one outstanding). Without it the
//               memory has a fixed one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_prefetch
  import ins_prefetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef PREFETCH_WAIT_EN
  input  logic              mem_ready,
`endif
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_take
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0]  SUM_LIMIT = SUM_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(RESET_PC);

  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_fetch_ptr;
  logic [ADDR_W-1:0] r_pc;

  logic              w_resp;
  logic              w_hold;
  logic              w_outstanding;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [SUM_W-1:0]  w_occ_sum;

`ifdef PREFETCH_WAIT_EN
  // Handshake memory: data arrives in the cycle ready is seen, and the
  // pending request stays on the bus until then.
  assign w_resp        = r_rd_en & mem_ready;
  assign w_hold        = r_rd_en & ~mem_ready;
  assign w_outstanding = w_hold;
`else
  // Fixed-latency memory: r_inflight marks that mem_rdata carries the reply
  // to the request driven in the previous cycle.
  logic r_inflight;

  assign w_resp        = r_inflight;
  assign w_hold        = 1'b0;
  assign w_outstanding = r_rd_en;

  // Track the single-cycle read pipeline; redirect and reset orphan it
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= r_rd_en;
    end
  end
`endif

  // A reply landing in a redirect cycle belongs to the old stream: drop it.
  assign w_push = w_resp & ~redirect & ~w_full;
  // Redirect beats take; take on an empty queue does nothing.
  assign w_pop  = ins_take & ~w_empty & ~redirect;

  // Credit check: queue after this edge's write, plus reads still owed,
  // must leave room. A same-cycle take is deliberately not credited.
  assign w_occ_sum = SUM_W'(w_count) + SUM_W'(w_push) + SUM_W'(w_outstanding);
  assign w_issue   = ~w_hold & (w_occ_sum < SUM_LIMIT);

  prefetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (w_push),
    .push_data (mem_rdata),
    .pop       (w_pop),
    .pop_data  (ins_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Fetch request generation, fetch pointer and head-of-queue PC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_fetch_ptr <= PC_RESET;
      r_pc        <= PC_RESET;
    end else if (redirect) begin
      r_rd_en     <= 1'b1;
      r_addr      <= redirect_addr;
      r_fetch_ptr <= redirect_addr + ADDR_W'(1);
      r_pc        <= redirect_addr;
    end else begin
      if (w_hold) begin
        r_rd_en <= 1'b1;
      end else if (w_issue) begin
        r_rd_en     <= 1'b1;
        r_addr      <= r_fetch_ptr;
        r_fetch_ptr <= r_fetch_ptr + ADDR_W'(1);
      end else begin
        r_rd_en <= 1'b0;
      end
      if (w_pop) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign ins_valid = ~w_empty;
  assign ins_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ins_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_prefetch
// Description : Self-checking bench for ins_prefetch (default build). Program
//               memory returns mem[a] = a[7:0] one cycle after the request.
//               The reference model tracks the expected head address, the
//               expected request stream and the restart timeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_prefetch;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
`ifdef PREFETCH_WAIT_EN
  logic              mem_ready;
`endif
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_take;

  ins_prefetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
`ifdef PREFETCH_WAIT_EN
    .mem_ready     (mem_ready),
`endif
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .ins_valid     (ins_valid),
    .ins_data      (ins_data),
    .ins_pc        (ins_pc),
    .ins_take      (ins_take)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [ADDR_W-1:0] m_pc;        // address the head byte must have
  logic [ADDR_W-1:0] m_next_req;  // address the next request must use
  int                m_req_cnt;   // requests since last restart
  int                m_taken;     // bytes consumed since last restart
  int                m_since;     // cycles since restart (1 = first request cycle)
  logic              m_in_rst;
  logic              armed;
  logic              have_req;
  logic [ADDR_W-1:0] req_addr_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_of(input logic [ADDR_W-1:0] a);
    return a[7:0];
  endfunction

  // One clock cycle: check outputs at the negedge, drive inputs, advance the
  // model across the rising edge, return at the next negedge.
  task automatic tick(input logic r, input logic rd, input logic [ADDR_W-1:0] ra,
                      input logic tk);
    logic v_now;
    if (armed) begin
      if (m_in_rst) begin
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_data",  32'(ins_data),  32'd0);
        check("rst_pc",    32'(ins_pc),    32'd0);
      end else begin
        if (mem_rd_en === 1'b1) begin
          check("req_addr", 32'(mem_addr), 32'(m_next_req));
          m_next_req = m_next_req + 16'd1;
          m_req_cnt++;
        end
        check("overfetch", 32'((m_req_cnt - m_taken) <= DEPTH), 32'd1);
        if (m_since == 1) check("restart_req", 32'(mem_rd_en), 32'd1);
        if (m_since == 1 || m_since == 2)
          check("restart_gap", 32'(ins_valid), 32'd0);
        else if (m_since >= 3)
          check("valid_live", 32'(ins_valid), 32'd1);
        if (ins_valid === 1'b1) begin
          check("head_pc",   32'(ins_pc),   32'(m_pc));
          check("head_data", 32'(ins_data), 32'(mem_of(m_pc)));
        end
      end
    end
    // Memory reply to last cycle's request, junk otherwise
    mem_rdata  = have_req ? mem_of(req_addr_q) : DATA_W'($urandom);
    have_req   = (mem_rd_en === 1'b1);
    req_addr_q = mem_addr;
    v_now = (ins_valid === 1'b1);
    rst = r; redirect = rd; redirect_addr = ra; ins_take = tk;
    @(posedge clk);
    if (r) begin
      m_pc = '0; m_next_req = '0; m_req_cnt = 0; m_taken = 0;
      m_since = 0; m_in_rst = 1'b1;
    end else begin
      m_in_rst = 1'b0;
      if (rd) begin
        m_pc = ra; m_next_req = ra; m_req_cnt = 0; m_taken = 0; m_since = 1;
      end else begin
        if (tk && v_now) begin
          m_pc = m_pc + 16'd1;
          m_taken++;
        end
        if (m_since < 1000) m_since++;
      end
    end
    armed = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    armed = 1'b0; have_req = 1'b0; req_addr_q = '0;
    m_pc = '0; m_next_req = '0; m_req_cnt = 0; m_taken = 0; m_since = 0;
    m_in_rst = 1'b1;
    rst = 1'b1; redirect = 1'b0; redirect_addr = '0; ins_take = 1'b0;
    mem_rdata = '0;
`ifdef PREFETCH_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(negedge clk);

    // Reset, then fill with no take: four sequential requests, then idle
    repeat (3) tick(1'b1, 1'b0, '0, 1'b0);
    repeat (8) tick(1'b0, 1'b0, '0, 1'b0);
    check("fill_req_cnt", 32'(m_req_cnt), 32'd4);
    check("fill_rd_idle", 32'(mem_rd_en), 32'd0);
    check("fill_data",    32'(ins_data),  32'h00);
    check("fill_pc",      32'(ins_pc),    32'h0000);

    // Continuous take: bytes 00,01,02,... one per cycle
    for (int i = 0; i < 20; i++) begin
      check("stream_data", 32'(ins_data), 32'(i));
      tick(1'b0, 1'b0, '0, 1'b1);
    end

    // Let the queue fill, then redirect (with a take that must be ignored)
    repeat (6) tick(1'b0, 1'b0, '0, 1'b0);
    check("full_before_redirect", 32'(m_req_cnt - m_taken), 32'(DEPTH));
    tick(1'b0, 1'b1, 16'h0123, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    check("redir_valid", 32'(ins_valid), 32'd1);
    check("redir_pc",    32'(ins_pc),    32'h0123);
    check("redir_data",  32'(ins_data),  32'h23);

    // Address wrap across the top of program space
    tick(1'b0, 1'b1, 16'hFFFE, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    check("wrap_pc0", 32'(ins_pc), 32'hFFFE);
    tick(1'b0, 1'b0, '0, 1'b1);
    check("wrap_pc1", 32'(ins_pc), 32'hFFFF);
    tick(1'b0, 1'b0, '0, 1'b1);
    check("wrap_pc2", 32'(ins_pc), 32'h0000);

    // Reset with a request in flight: reply ignored, refetch from 0000
    check("pre_rst_req", 32'(mem_rd_en), 32'd1);
    tick(1'b1, 1'b0, '0, 1'b1);
    check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid_rst_valid", 32'(ins_valid), 32'd0);
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
    check("after_rst_pc",   32'(ins_pc),   32'h0000);
    check("after_rst_data", 32'(ins_data), 32'h00);

    // Randomised traffic: takes, redirects (often near the wrap), resets
    for (int i = 0; i < 600; i++) begin
      logic r, rd, tk;
      logic [ADDR_W-1:0] ra;
      r  = ($urandom_range(0, 149) == 0);
      rd = ($urandom_range(0, 15) == 0);
      tk = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                       : 16'($urandom);
      tick(r, rd, ra, tk);
    end
    repeat (4) tick(1'b0, 1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
